// File: rtl/itof_converter_pipe_pkg.sv
// ---------------------------------------------------------------------------
// itof_converter_pipe_pkg
// Shared FPU definitions used by the integer-to-float converter:
//   - fpu_op_e : FPU opcodes, including the 64-bit source converts
//                FPU_OP_CVTLF / FPU_OP_CVTLUF
//   - rm_e     : rounding-mode encodings RM_RNE..RM_RMM
//   - bias()   : IEEE exponent bias for a given exponent width
// ---------------------------------------------------------------------------
package itof_converter_pipe_pkg;

    typedef enum logic [4:0] {
        FPU_OP_ADD    = 5'd0,
        FPU_OP_SUB    = 5'd1,
        FPU_OP_MUL    = 5'd2,
        FPU_OP_CVTIF  = 5'd8,   // signed 32-bit  -> float
        FPU_OP_CVTUF  = 5'd9,   // unsigned 32-bit -> float
        FPU_OP_CVTLF  = 5'd10,  // signed 64-bit  -> float
        FPU_OP_CVTLUF = 5'd11   // unsigned 64-bit -> float
    } fpu_op_e;

    typedef enum logic [2:0] {
        RM_RNE = 3'd0,  // round to nearest, ties to even
        RM_RTZ = 3'd1,  // round toward zero
        RM_RDN = 3'd2,  // round toward -infinity
        RM_RUP = 3'd3,  // round toward +infinity
        RM_RMM = 3'd4   // round to nearest, ties away from zero
    } rm_e;

    // Exponent bias 2^(exp_width-1) - 1
    function automatic int bias(input int exp_width);
        return (32'sd1 <<< (exp_width - 32'sd1)) - 32'sd1;
    endfunction

endpackage

// File: rtl/itof_converter_pipe_lzc.sv
// ---------------------------------------------------------------------------
// leading_zero_counter_param
// Combinational leading-zero counter.
//   value    : operand, WIDTH bits
//   count    : number of zeros above the most significant set bit
//              (0 when all_zero is set)
//   all_zero : operand is zero
// ---------------------------------------------------------------------------
module leading_zero_counter_param #(
    parameter int WIDTH = 64,
    parameter int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] value,
    output logic [CNT_W-1:0] count,
    output logic             all_zero
);

    // Scan upward so the highest set bit is the last one to update the count
    always_comb begin
        count    = {CNT_W{1'b0}};
        all_zero = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if (value[i]) begin
                count    = CNT_W'(WIDTH - 1 - i);
                all_zero = 1'b0;
            end else begin
                count    = count;
                all_zero = all_zero;
            end
        end
    end

endmodule

// File: rtl/itof_converter_pipe.sv
// ---------------------------------------------------------------------------
// itof_converter_pipe
// Two-stage pipelined integer-to-float converter (32/64-bit, signed or
// unsigned source; IEEE destination with EXP_WIDTH/MAN_WIDTH fields).
//   Stage 1: source extraction, sign/magnitude, normalisation, exponent.
//   Stage 2: truncation, guard/sticky, rounding, inexact flag.
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   valid_in / ready_out operand handshake
//   valid_out / ready_in result handshake
//   op                   FPU_OP_CVTIF / CVTUF / CVTLF / CVTLUF
//   rm                   rounding mode (101-111 behave as RNE)
//   int_in               integer operand ([31:0] only for W ops)
//   float_out            {sign, exponent, mantissa}
//   IE                   inexact flag, qualified by valid_out
//
// Build option ITOF_SKID_EN: adds a one-entry skid register after stage 2 so
// that ready_out is computed from registered state only (capacity 3).
// ---------------------------------------------------------------------------
module itof_converter_pipe
    import itof_converter_pipe_pkg::*;
#(
    parameter int INT_WIDTH = 64,
    parameter int EXP_WIDTH = 11,
    parameter int MAN_WIDTH = 52
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           valid_in,
    output logic                           ready_out,
    output logic                           valid_out,
    input  logic                           ready_in,
    input  logic [4:0]                     op,
    input  logic [2:0]                     rm,
    input  logic [INT_WIDTH-1:0]           int_in,
    output logic [EXP_WIDTH+MAN_WIDTH:0]   float_out,
    output logic                           IE
);

    localparam int FW   = 1 + EXP_WIDTH + MAN_WIDTH;
    localparam int LZ_W = $clog2(INT_WIDTH);
    // Bits below the hidden one, padded so guard/sticky always exist
    localparam int EW   = (INT_WIDTH - 1) + MAN_WIDTH + 2;

    // ---------------- stage 1 combinational ----------------
    logic                 is_w_s, is_l_s, is_signed_s, legal_s;
    logic [63:0]          w_ext_s;
    logic [INT_WIDTH-1:0] src_s, mag_s, norm_s;
    logic                 sign_s, all_zero_s, accept_s;
    logic [LZ_W-1:0]      lz_s;
    logic [EXP_WIDTH-1:0] exp_s;
    int                   exp_calc_s;

    // ---------------- stage registers ----------------
    logic                 s1_valid_r, s1_sign_r;
    logic [2:0]           s1_rm_r;
    logic [INT_WIDTH-1:0] s1_norm_r;
    logic [EXP_WIDTH-1:0] s1_exp_r;
    logic                 s2_valid_r, s2_ie_r;
    logic [FW-1:0]        s2_float_r;

    // ---------------- stage 2 combinational ----------------
    logic [EW-1:0]                  ext_s;
    logic [MAN_WIDTH-1:0]           mant_s;
    logic                           guard_s, sticky_s, round_up_s;
    logic [EXP_WIDTH+MAN_WIDTH-1:0] mag_sum_s;
    logic [FW-1:0]                  res_s;

    // ---------------- handshake ----------------
    logic s1_load_s, s2_load_s;

    // Opcode decode; L ops exist only on a 64-bit datapath
    always_comb begin
        is_w_s      = 1'b0;
        is_l_s      = 1'b0;
        is_signed_s = 1'b0;
        case (op)
            FPU_OP_CVTIF:  begin is_w_s = 1'b1; is_signed_s = 1'b1; end
            FPU_OP_CVTUF:  begin is_w_s = 1'b1; end
            FPU_OP_CVTLF:  begin is_l_s = 1'b1; is_signed_s = 1'b1; end
            FPU_OP_CVTLUF: begin is_l_s = 1'b1; end
            default:       begin is_w_s = 1'b0; end
        endcase
        if (INT_WIDTH == 64) begin
            legal_s = is_w_s | is_l_s;
        end else begin
            legal_s = is_w_s;
        end
    end

    // Source extraction, sign and magnitude
    always_comb begin
        if (is_signed_s) begin
            w_ext_s = {{32{int_in[31]}}, int_in[31:0]};
        end else begin
            w_ext_s = {32'h0000_0000, int_in[31:0]};
        end
        if (is_w_s) begin
            src_s = w_ext_s[INT_WIDTH-1:0];
        end else begin
            src_s = int_in;
        end
        sign_s = is_signed_s & src_s[INT_WIDTH-1];
        // The most-negative value negates to itself, which read unsigned is
        // exactly the required magnitude 2^(N-1).
        if (sign_s) begin
            mag_s = ~src_s + {{(INT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            mag_s = src_s;
        end
    end

    leading_zero_counter_param #(
        .WIDTH (INT_WIDTH),
        .CNT_W (LZ_W)
    ) u_lzc (
        .value    (mag_s),
        .count    (lz_s),
        .all_zero (all_zero_s)
    );

    // Normalisation and biased exponent; zero maps to a zero exponent
    always_comb begin
        norm_s     = mag_s << lz_s;
        exp_calc_s = bias(EXP_WIDTH) + INT_WIDTH - 32'sd1 - int'(lz_s);
        if (all_zero_s) begin
            exp_s = {EXP_WIDTH{1'b0}};
        end else begin
            exp_s = EXP_WIDTH'(exp_calc_s);
        end
    end

    // Truncation, guard/sticky extraction and rounding decision
    always_comb begin
        ext_s    = {s1_norm_r[INT_WIDTH-2:0], {(MAN_WIDTH+2){1'b0}}};
        mant_s   = ext_s[EW-1 -: MAN_WIDTH];
        guard_s  = ext_s[EW-1-MAN_WIDTH];
        sticky_s = |ext_s[EW-2-MAN_WIDTH:0];
        case (s1_rm_r)
            RM_RTZ:  round_up_s = 1'b0;
            RM_RDN:  round_up_s = s1_sign_r & (guard_s | sticky_s);
            RM_RUP:  round_up_s = ~s1_sign_r & (guard_s | sticky_s);
            RM_RMM:  round_up_s = guard_s;
            default: round_up_s = guard_s & (sticky_s | mant_s[0]);
        endcase
        // A mantissa carry ripples straight into the exponent field
        mag_sum_s = {s1_exp_r, mant_s}
                  + {{(EXP_WIDTH+MAN_WIDTH-1){1'b0}}, round_up_s};
        res_s     = {s1_sign_r, mag_sum_s};
    end

`ifdef ITOF_SKID_EN
    logic          sk_valid_r, sk_ie_r;
    logic [FW-1:0] sk_float_r;
    logic          adv_s;

    // Pipeline advances whenever the skid is empty; ready_out is registered-only
    always_comb begin
        adv_s     = ~sk_valid_r;
        s1_load_s = adv_s;
        s2_load_s = adv_s;
        ready_out = legal_s & ~sk_valid_r;
        accept_s  = valid_in & ready_out;
    end

    // Skid register: catches the stage-2 result stalled while the pipe advances
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sk_valid_r <= 1'b0;
            sk_float_r <= {FW{1'b0}};
            sk_ie_r    <= 1'b0;
        end else if (sk_valid_r) begin
            if (ready_in) begin
                sk_valid_r <= 1'b0;
            end
        end else if (s2_valid_r && !ready_in) begin
            sk_valid_r <= 1'b1;
            sk_float_r <= s2_float_r;
            sk_ie_r    <= s2_ie_r;
        end
    end

    // Oldest result is in the skid whenever it is occupied
    always_comb begin
        if (sk_valid_r) begin
            valid_out = 1'b1;
            float_out = sk_float_r;
            IE        = sk_ie_r;
        end else begin
            valid_out = s2_valid_r;
            float_out = s2_float_r;
            IE        = s2_ie_r;
        end
    end
`else
    // Elastic handshake: a stage loads when empty or when its contents leave
    always_comb begin
        s2_load_s = ~s2_valid_r | ready_in;
        s1_load_s = ~s1_valid_r | s2_load_s;
        ready_out = legal_s & s1_load_s;
        accept_s  = valid_in & ready_out;
    end

    // Outputs come straight from the stage-2 register
    always_comb begin
        valid_out = s2_valid_r;
        float_out = s2_float_r;
        IE        = s2_ie_r;
    end
`endif

    // Stage-1 register: normalised operand
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            s1_sign_r  <= 1'b0;
            s1_rm_r    <= 3'd0;
            s1_norm_r  <= {INT_WIDTH{1'b0}};
            s1_exp_r   <= {EXP_WIDTH{1'b0}};
        end else if (s1_load_s) begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_sign_r <= sign_s;
                s1_rm_r   <= rm;
                s1_norm_r <= norm_s;
                s1_exp_r  <= exp_s;
            end
        end
    end

    // Stage-2 register: rounded result and inexact flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid_r <= 1'b0;
            s2_float_r <= {FW{1'b0}};
            s2_ie_r    <= 1'b0;
        end else if (s2_load_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_float_r <= res_s;
                s2_ie_r    <= guard_s | sticky_s;
            end
        end
    end

endmodule
